// File: rtl/bram_sp_ctrl.sv
// bram_sp_ctrl: valid/ready initiator for a single-port BRAM with a credit-protected 4-entry read response FIFO.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_req_valid/o_req_ready        request handshake; i_req_rw (1 = write), i_req_addr, i_req_data
//   o_rsp_valid/i_rsp_ready        response handshake; o_rsp_data is the FIFO head (show-ahead)
//   o_mem_en/rw/addr/data          registered BRAM command pins
//   i_mem_data, i_mem_dv           BRAM read data and its valid strobe
//   o_busy                         reads outstanding or a command in the issue stage
//   o_err                          sticky: read data strobe seen with no read in flight
module bram_sp_ctrl #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_rw,
    input  logic [AW-1:0]    i_req_addr,
    input  logic [WIDTH-1:0] i_req_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_mem_en,
    output logic             o_mem_rw,
    output logic [AW-1:0]    o_mem_addr,
    output logic [WIDTH-1:0] o_mem_data,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic             i_mem_dv,
    output logic             o_busy,
    output logic             o_err
);
    logic [2:0]       outst;
    logic [1:0]       trk;
    logic [2:0]       cnt;
    logic [1:0]       wp, rp;
    logic [WIDTH-1:0] fifo [4];
    logic             accept, rd_acc, pop, issued, push;

    // A credit is reserved at read acceptance, so the FIFO can never hold more than four words.
    assign o_req_ready = rstn && (outst < 3'd4);
    assign accept      = i_req_valid && o_req_ready;
    assign rd_acc      = accept && !i_req_rw;
    assign pop         = o_rsp_valid && i_rsp_ready;
    assign issued      = o_mem_en && !o_mem_rw;
    // Data strobes with nothing in flight (including reads lost across a reset) are dropped.
    assign push        = i_mem_dv && (trk != 2'd0);
    assign o_rsp_valid = cnt != 3'd0;
    assign o_rsp_data  = fifo[rp];
    assign o_busy      = (outst != 3'd0) || o_mem_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_mem_en   <= 1'b0;
            o_mem_rw   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            outst      <= '0;
            trk        <= '0;
            cnt        <= '0;
            wp         <= '0;
            rp         <= '0;
            o_err      <= 1'b0;
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
        end else begin
            o_mem_en <= accept;
            if (accept) begin
                o_mem_rw   <= i_req_rw;
                o_mem_addr <= i_req_addr;
                o_mem_data <= i_req_data;
            end
            outst <= outst + 3'(rd_acc) - 3'(pop);
            trk   <= trk + 2'(issued) - 2'(push);
            cnt   <= cnt + 3'(push) - 3'(pop);
            if (push) begin
                fifo[wp] <= i_mem_data;
                wp       <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            if (i_mem_dv && trk == 2'd0) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bram_sp_ctrl.sv
// tb_bram_sp_ctrl: self-checking bench for bram_sp_ctrl with a behavioural BRAM and a transaction-level scoreboard.
module tb_bram_sp_ctrl;
    localparam int WIDTH = 36;
    localparam int DEPTH = 1024;
    localparam int AW = 10;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_req_valid = 1'b0, i_req_rw = 1'b0, i_rsp_ready = 1'b0;
    logic [AW-1:0]    i_req_addr = '0;
    logic [WIDTH-1:0] i_req_data = '0;
    logic             o_req_ready, o_rsp_valid, o_mem_en, o_mem_rw, o_busy, o_err;
    logic [WIDTH-1:0] o_rsp_data, o_mem_data, i_mem_data;
    logic [AW-1:0]    o_mem_addr;
    logic             i_mem_dv;

    logic             model_dv = 1'b0, inj_dv = 1'b0;
    logic [WIDTH-1:0] model_q = '0, inj_data = '0;
    logic [WIDTH-1:0] bram [DEPTH];
    bit               bram_wr [DEPTH];

    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               ref_wr [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int               outst_m = 0;
    int               total = 0, bad = 0;

    bram_sp_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rw(i_req_rw),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_mem_en(o_mem_en), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .i_mem_data(i_mem_data), .i_mem_dv(i_mem_dv), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM: unwritten words read as addr+0x100, read data one cycle after en.
    assign i_mem_dv   = model_dv | inj_dv;
    assign i_mem_data = inj_dv ? inj_data : model_q;
    always @(posedge clk) begin
        if (o_mem_en && o_mem_rw) begin
            bram[o_mem_addr]    <= o_mem_data;
            bram_wr[o_mem_addr] <= 1'b1;
        end
        model_dv <= o_mem_en && !o_mem_rw;
        model_q  <= bram_wr[o_mem_addr] ? bram[o_mem_addr] : WIDTH'(o_mem_addr) + 36'h100;
    end

    function automatic logic [WIDTH-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : WIDTH'(a) + 36'h100;
    endfunction

    // Scoreboard: every accepted read must come back, in order, with the value the address held at acceptance.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            outst_m = 0;
        end else begin
            total++;
            if (o_req_ready !== 1'(outst_m < 4)) begin
                bad++;
                $display("FAIL sb_ready: got %0b want %0b (outstanding %0d)", o_req_ready, outst_m < 4, outst_m);
            end
            if (o_rsp_valid && i_rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_rsp: unexpected response %h", o_rsp_data);
                end else begin
                    if (o_rsp_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL sb_rsp: got %h want %h", o_rsp_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    outst_m--;
                end
            end
            if (i_req_valid && o_req_ready) begin
                if (i_req_rw) begin
                    ref_mem[i_req_addr] = i_req_data;
                    ref_wr[i_req_addr]  = 1'b1;
                end else begin
                    exp_q.push_back(ref_rd(i_req_addr));
                    outst_m++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 4;
        if ({o_req_ready, o_mem_en, o_mem_rw, o_rsp_valid, o_busy, o_err} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000000", {o_req_ready, o_mem_en, o_mem_rw, o_rsp_valid, o_busy, o_err});
        end
        if (o_mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
        if (o_mem_data !== '0) begin bad++; $display("FAIL reset_mdata: got %h want 0", o_mem_data); end
        if (o_rsp_data !== '0) begin bad++; $display("FAIL reset_rdata: got %h want 0", o_rsp_data); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        total++;
        if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_req_ready); end
    endtask

    task automatic test_back_to_back;
        int k = 0, first = -1, last = -1;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            i_req_valid = c < 8;
            i_req_rw    = 1'b0;
            i_req_addr  = AW'(c);
            if (c < 8) begin
                total++;
                if (o_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: cycle %0d got %b want 1", c, o_req_ready); end
            end
            if (o_rsp_valid) begin
                total++;
                if (o_rsp_data !== WIDTH'(32'h100 + k)) begin
                    bad++;
                    $display("FAIL b2b_data: got %h want %h", o_rsp_data, WIDTH'(32'h100 + k));
                end
                if (first < 0) first = c;
                last = c;
                k++;
            end
            tick();
        end
        total += 2;
        if (k !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", k); end
        if (first !== 3 || last !== 10) begin bad++; $display("FAIL b2b_timing: got %0d..%0d want 3..10", first, last); end
    endtask

    task automatic test_write_read;
        logic [WIDTH-1:0] x = 36'h123456789;
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_rw = 1'b1; i_req_addr = 10'd5; i_req_data = x;
        tick();
        i_req_rw = 1'b0; i_req_data = '0;
        total += 2;
        if ({o_mem_en, o_mem_rw, o_mem_addr, o_mem_data} !== {2'b11, 10'd5, x}) begin
            bad++;
            $display("FAIL wr_issue: got en=%b rw=%b a=%0d d=%h want en=1 rw=1 a=5 d=%h", o_mem_en, o_mem_rw, o_mem_addr, o_mem_data, x);
        end
        if (o_busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", o_busy); end
        tick();
        i_req_valid = 1'b0;
        total++;
        if ({o_mem_en, o_mem_rw, o_mem_addr} !== {2'b10, 10'd5}) begin
            bad++;
            $display("FAIL rd_issue: got en=%b rw=%b a=%0d want en=1 rw=0 a=5", o_mem_en, o_mem_rw, o_mem_addr);
        end
        tick();
        total++;
        if ({o_mem_en, o_rsp_valid} !== 2'b00) begin bad++; $display("FAIL rd_early: got en=%b v=%b want 00", o_mem_en, o_rsp_valid); end
        tick();
        total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_data !== x) begin
            bad++;
            $display("FAIL rd_latency: got v=%b d=%h want v=1 d=%h", o_rsp_valid, o_rsp_data, x);
        end
        tick();
    endtask

    task automatic test_backpressure;
        int acc = 0;
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = AW'(acc);
            if (o_req_ready) acc++;
            tick();
        end
        total += 2;
        if (acc !== 4) begin bad++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        if ({o_req_ready, o_rsp_valid} !== 2'b01) begin bad++; $display("FAIL bp_stall: got rdy=%b v=%b want rdy=0 v=1", o_req_ready, o_rsp_valid); end
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            i_req_valid = acc < 6;
            i_req_addr  = AW'(acc);
            if (i_req_valid && o_req_ready) acc++;
            tick();
        end
        total += 2;
        if (acc !== 6) begin bad++; $display("FAIL bp_resume: got %0d want 6", acc); end
        if ({o_rsp_valid, o_busy} !== 2'b00) begin bad++; $display("FAIL bp_drain: got v=%b busy=%b want 00", o_rsp_valid, o_busy); end
    endtask

    task automatic test_write_stall;
        logic [WIDTH-1:0] x = WIDTH'({$urandom(), $urandom()});
        logic [WIDTH-1:0] last = '0;
        bit wa = 1'b0, ra = 1'b0;
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = AW'(10 + c);
            tick();
        end
        i_req_rw = 1'b1; i_req_addr = 10'd20; i_req_data = x;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({o_req_ready, o_mem_en} !== 2'b00) begin bad++; $display("FAIL ws_blocked: got rdy=%b en=%b want 00", o_req_ready, o_mem_en); end
            tick();
        end
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 10 && !wa; c++) begin
            wa = o_req_ready;
            tick();
        end
        total++;
        if (!wa || {o_mem_en, o_mem_rw, o_mem_addr, o_mem_data} !== {2'b11, 10'd20, x}) begin
            bad++;
            $display("FAIL ws_issue: got acc=%b en=%b rw=%b a=%0d d=%h want acc=1 en=1 rw=1 a=20 d=%h", wa, o_mem_en, o_mem_rw, o_mem_addr, o_mem_data, x);
        end
        i_req_rw = 1'b0;
        for (int c = 0; c < 10 && !ra; c++) begin
            ra = o_req_ready;
            tick();
        end
        i_req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (o_rsp_valid) last = o_rsp_data;
            tick();
        end
        total++;
        if (!ra || last !== x) begin bad++; $display("FAIL ws_readback: got acc=%b d=%h want acc=1 d=%h", ra, last, x); end
    endtask

    task automatic test_spurious;
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        repeat (2) tick();
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL sp_pre: got err=%b want 0", o_err); end
        inj_data = WIDTH'({$urandom(), $urandom()});
        inj_dv = 1'b1;
        tick();
        inj_dv = 1'b0;
        total++;
        if ({o_err, o_rsp_valid} !== 2'b10) begin bad++; $display("FAIL sp_err: got err=%b v=%b want err=1 v=0", o_err, o_rsp_valid); end
        repeat (4) tick();
        total++;
        if ({o_err, o_rsp_valid, o_busy} !== 3'b100) begin bad++; $display("FAIL sp_sticky: got err=%b v=%b busy=%b want 100", o_err, o_rsp_valid, o_busy); end
    endtask

    task automatic test_reset_mid;
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 10'd3;
        tick();
        i_req_valid = 1'b0;
        total++;
        if (o_mem_en !== 1'b1) begin bad++; $display("FAIL rm_issue: got en=%b want 1", o_mem_en); end
        tick();
        rstn = 1'b0;
        #1;
        total++;
        if ({o_req_ready, o_mem_en, o_rsp_valid, o_busy, o_err} !== 5'b0 || o_mem_addr !== '0 || o_mem_data !== '0) begin
            bad++;
            $display("FAIL rm_clear: got rdy=%b en=%b v=%b busy=%b err=%b a=%h d=%h want all 0", o_req_ready, o_mem_en, o_rsp_valid, o_busy, o_err, o_mem_addr, o_mem_data);
        end
        @(negedge clk);
        #1 rstn = 1'b1;
        tick();
        total++;
        if ({o_err, o_rsp_valid} !== 2'b10) begin bad++; $display("FAIL rm_late_dv: got err=%b v=%b want err=1 v=0", o_err, o_rsp_valid); end
        repeat (3) tick();
        total++;
        if ({o_err, o_rsp_valid} !== 2'b10) begin bad++; $display("FAIL rm_after: got err=%b v=%b want err=1 v=0", o_err, o_rsp_valid); end
    endtask

    task automatic test_random;
        rstn = 1'b0;
        tick();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        for (int c = 0; c < 400; c++) begin
            i_req_valid = $urandom_range(0, 9) < 6;
            i_req_rw    = $urandom_range(0, 2) == 0;
            i_req_addr  = AW'($urandom_range(0, 15));
            i_req_data  = WIDTH'({$urandom(), $urandom()});
            i_rsp_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        repeat (20) tick();
        total++;
        if (exp_q.size() !== 0 || {o_busy, o_err, o_rsp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL rnd_drain: got pending=%0d busy=%b err=%b v=%b want 0 000", exp_q.size(), o_busy, o_err, o_rsp_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_write_read();
        test_backpressure();
        test_write_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
